// File: rtl/nand_sched_pkg.sv
// rtl/nand_sched_pkg.sv - shared types and defaults for the round-robin NAND scheduler
package nand_sched_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int W_DEF     = 1;
  localparam int ID_W      = $clog2(N_REQ_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nand_rr_scheduler_if.sv
// rtl/nand_rr_scheduler_if.sv - requester/result bundle between input decode, scheduler and output mux
interface nand_rr_scheduler_if
  import nand_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int W     = W_DEF
);

  localparam int IDW = $clog2(N_REQ);

  logic                 ena;
  logic [N_REQ-1:0]     req;
  logic [N_REQ*W-1:0]   op_a;
  logic [N_REQ*W-1:0]   op_b;
  logic [N_REQ-1:0]     gnt;
  logic                 res_valid;
  logic [IDW-1:0]       res_id;
  logic [W-1:0]         res_data;
  logic                 busy;

  modport master (
    output ena, req, op_a, op_b,
    input  gnt, res_valid, res_id, res_data, busy
  );

  modport slave (
    input  ena, req, op_a, op_b,
    output gnt, res_valid, res_id, res_data, busy
  );

endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first set req at or after ptr, wrapping
module rr_pick #(
  parameter int  N_REQ = 4,
  localparam int IDW   = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   ptr,
  output logic             any,
  output logic [IDW-1:0]   winner
);

  logic [2*N_REQ-1:0] dbl;

  // Upper copy stays fully unmasked, so the lowest surviving bit is the wrapped winner.
  always_comb begin
    dbl    = {req, req} & ({(2*N_REQ){1'b1}} << ptr);
    any    = |req;
    winner = '0;
    for (int i = 2*N_REQ-1; i >= 0; i--) begin
      if (dbl[i]) begin
        winner = IDW'(i % N_REQ);
      end
    end
  end

endmodule

// File: rtl/nand_rr_scheduler.sv
// rtl/nand_rr_scheduler.sv - shares one NAND unit among N_REQ requesters, round-robin, tagged results
module nand_rr_scheduler
  import nand_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int W     = W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  nand_rr_scheduler_if.slave bus
);

  localparam int IDW = $clog2(N_REQ);

  state_t           state, state_nx;
  logic [IDW-1:0]   ptr, ptr_nx;
  logic [IDW-1:0]   id_q, id_q_nx;
  logic [W-1:0]     a_q, a_q_nx;
  logic [W-1:0]     b_q, b_q_nx;
  logic [N_REQ-1:0] gnt, gnt_nx;
  logic             res_valid, res_valid_nx;
  logic [IDW-1:0]   res_id, res_id_nx;
  logic [W-1:0]     res_data, res_data_nx;
  logic             pick_any;
  logic [IDW-1:0]   pick_id;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req    (bus.req),
    .ptr    (ptr),
    .any    (pick_any),
    .winner (pick_id)
  );

  always_comb begin
    state_nx     = state;
    ptr_nx       = ptr;
    id_q_nx      = id_q;
    a_q_nx       = a_q;
    b_q_nx       = b_q;
    gnt_nx       = gnt;
    res_valid_nx = res_valid;
    res_id_nx    = res_id;
    res_data_nx  = res_data;
    case (state)
      IDLE: begin
        gnt_nx       = '0;
        res_valid_nx = 1'b0;
        if (pick_any) begin
          gnt_nx[pick_id] = 1'b1;
          a_q_nx          = bus.op_a[pick_id*W +: W];
          b_q_nx          = bus.op_b[pick_id*W +: W];
          id_q_nx         = pick_id;
          state_nx        = EXEC;
        end
      end
      EXEC: begin
        // Result registers load here so res_valid/res_data/res_id appear together in DONE.
        gnt_nx       = '0;
        res_data_nx  = ~(a_q & b_q);
        res_id_nx    = id_q;
        res_valid_nx = 1'b1;
        state_nx     = DONE;
      end
      DONE: begin
        gnt_nx       = '0;
        res_valid_nx = 1'b0;
        ptr_nx       = (id_q == IDW'(N_REQ-1)) ? '0 : id_q + IDW'(1);
        state_nx     = IDLE;
      end
      default: begin
        gnt_nx       = '0;
        res_valid_nx = 1'b0;
        state_nx     = IDLE;
      end
    endcase
  end

  // ena low freezes everything, which also stretches any pulse already on gnt/res_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      id_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      gnt       <= '0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_data  <= '0;
    end else if (bus.ena) begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      id_q      <= id_q_nx;
      a_q       <= a_q_nx;
      b_q       <= b_q_nx;
      gnt       <= gnt_nx;
      res_valid <= res_valid_nx;
      res_id    <= res_id_nx;
      res_data  <= res_data_nx;
    end
  end

  assign bus.gnt       = gnt;
  assign bus.res_valid = res_valid;
  assign bus.res_id    = res_id;
  assign bus.res_data  = res_data;
  assign bus.busy      = (state != IDLE);

endmodule
